// File: rtl/cursor_brush_painter_pkg.sv
// Shared definitions for the cursor brush painter.
//   Screen geometry, port widths, internal arithmetic widths and the
//   controller state type used by cursor_brush_painter and brush_scan_gen.
package cbp_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COORD_W  = 16;
   localparam int COLOR_W  = 16;
   localparam int ADDR_W   = 17;
   localparam int RAD_W    = 3;

   // Brush offsets span -7..+7; one spare bit keeps +r and -r both representable.
   localparam int OFS_W    = RAD_W + 2;
   // Cursor plus offset, signed, wide enough that an off-screen cursor never wraps on screen.
   localparam int ARITH_W  = 18;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/cursor_brush_painter_brush_scan_gen.sv
// Brush candidate generator.
//   Walks the (dx, dy) offsets of a square brush in row-major order
//   (dx inner, dy outer) and reports, for the current candidate, whether it
//   is on screen and its framebuffer word address.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   init           load radius and start at dx = dy = -radius
//   radius         brush half-size, sampled on init
//   cx, cy         brush centre (held stable by the caller while scanning)
//   advance        step to the next candidate
//   last           current candidate is dx = dy = +radius
//   inb            current candidate lies inside the visible screen
//   addr           y*SCREEN_W + x of the current candidate (valid when inb)
module brush_scan_gen
   import cbp_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               init,
   input  logic [RAD_W-1:0]   radius,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic               advance,
   output logic               last,
   output logic               inb,
   output logic [ADDR_W-1:0]  addr
);

   localparam logic signed [OFS_W-1:0]   ONE_S    = OFS_W'(1);
   localparam logic signed [ARITH_W-1:0] SCR_W_S  = ARITH_W'(SCREEN_W);
   localparam logic signed [ARITH_W-1:0] SCR_H_S  = ARITH_W'(SCREEN_H);
   localparam logic        [ADDR_W-1:0]  SCR_W_A  = ADDR_W'(SCREEN_W);

   logic        [RAD_W-1:0]   rad;
   logic signed [OFS_W-1:0]   dx;
   logic signed [OFS_W-1:0]   dy;
   logic signed [OFS_W-1:0]   rad_s;
   logic signed [OFS_W-1:0]   rad_in_s;
   logic signed [ARITH_W-1:0] x;
   logic signed [ARITH_W-1:0] y;

   assign rad_s    = $signed({{(OFS_W-RAD_W){1'b0}}, rad});
   assign rad_in_s = $signed({{(OFS_W-RAD_W){1'b0}}, radius});

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rad <= '0;
         dx  <= '0;
         dy  <= '0;
      end else if (init) begin
         rad <= radius;
         dx  <= -rad_in_s;
         dy  <= -rad_in_s;
      end else if (advance) begin
         if (dx == rad_s) begin
            dx <= -rad_s;
            dy <= dy + ONE_S;
         end else begin
            dx <= dx + ONE_S;
         end
      end
   end

   assign x = $signed({2'b00, cx}) + $signed({{(ARITH_W-OFS_W){dx[OFS_W-1]}}, dx});
   assign y = $signed({2'b00, cy}) + $signed({{(ARITH_W-OFS_W){dy[OFS_W-1]}}, dy});

   assign last = (dx == rad_s) && (dy == rad_s);
   assign inb  = !x[ARITH_W-1] && (x < SCR_W_S) && !y[ARITH_W-1] && (y < SCR_H_S);
   // Only meaningful when inb; out-of-range candidates are never written.
   assign addr = y[ADDR_W-1:0] * SCR_W_A + x[ADDR_W-1:0];

endmodule

// File: rtl/cursor_brush_painter.sv
// Cursor brush painter.
//   While paint_en is high, stamps a square brush of brush_color centred on
//   the cursor into the framebuffer, one pixel write per on-screen brush
//   pixel over a valid/ready handshake. A stationary cursor stamps once.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cursor_x, cursor_y      cursor position (unsigned)
//   brush_color             colour of the next stamp
//   brush_radius            brush half-size, side = 2r+1
//   paint_en                painting requested (level)
//   pix_valid/pix_ready     pixel write handshake
//   pix_addr, pix_data      pixel write address and colour
//   busy                    stamp in progress
//   stamp_count             completed stamps, wrapping
//
// state | meaning
// IDLE  | wait for paint_en with a new (or first) cursor position
// LOAD  | latch cursor, colour and radius; start the offset walk
// SCAN  | present one brush candidate per cycle; hold while a write stalls
// DONE  | record stamped position, count the stamp, return to IDLE
module cursor_brush_painter
   import cbp_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] cursor_x,
   input  logic [COORD_W-1:0] cursor_y,
   input  logic [COLOR_W-1:0] brush_color,
   input  logic [RAD_W-1:0]   brush_radius,
   input  logic               paint_en,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [ADDR_W-1:0]  pix_addr,
   output logic [COLOR_W-1:0] pix_data,
   output logic               busy,
   output logic [15:0]        stamp_count
);

   state_t             state;
   logic               armed;
   logic               pend;
   logic               pres_last;
   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic [COORD_W-1:0] last_x;
   logic [COORD_W-1:0] last_y;
   logic [COLOR_W-1:0] color;

   logic               trigger;
   logic               out_free;
   logic               init;
   logic               advance;
   logic               sg_last;
   logic               sg_inb;
   logic [ADDR_W-1:0]  sg_addr;

   assign trigger  = paint_en && (!armed || (cursor_x != last_x) || (cursor_y != last_y));
   assign out_free = !pix_valid || pix_ready;
   assign init     = (state == LOAD);
   // The generator always points one candidate ahead of the output register:
   // it advances exactly when its candidate is loaded into the output.
   // pend=0 marks the first SCAN cycle, where nothing is presented yet.
   assign advance  = (state == SCAN) && (!pend || (out_free && !pres_last));

   brush_scan_gen u_scan (
      .clk     (clk),
      .reset_n (reset_n),
      .init    (init),
      .radius  (brush_radius),
      .cx      (cx),
      .cy      (cy),
      .advance (advance),
      .last    (sg_last),
      .inb     (sg_inb),
      .addr    (sg_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         armed       <= 1'b0;
         pend        <= 1'b0;
         pres_last   <= 1'b0;
         cx          <= '0;
         cy          <= '0;
         last_x      <= '0;
         last_y      <= '0;
         color       <= '0;
         pix_valid   <= 1'b0;
         pix_addr    <= '0;
         pix_data    <= '0;
         busy        <= 1'b0;
         stamp_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end else if (!paint_en) begin
                  armed <= 1'b0;
               end
            end
            LOAD: begin
               cx    <= cursor_x;
               cy    <= cursor_y;
               color <= brush_color;
               pend  <= 1'b0;
               state <= SCAN;
            end
            SCAN: begin
               if (advance) begin
                  pix_valid <= sg_inb;
                  pix_addr  <= sg_addr;
                  pix_data  <= color;
                  pres_last <= sg_last;
                  pend      <= 1'b1;
               end else if (out_free) begin
                  // last candidate accepted or skipped
                  pix_valid <= 1'b0;
                  pend      <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               last_x      <= cx;
               last_y      <= cy;
               armed       <= 1'b1;
               stamp_count <= stamp_count + 16'd1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cursor_brush_painter.sv
// Testbench for cursor_brush_painter: directed scenarios plus randomized
// stamps, checked against a brush-rasterising reference model.
module tb_cursor_brush_painter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] cursor_x;
   logic [15:0] cursor_y;
   logic [15:0] brush_color;
   logic [2:0]  brush_radius;
   logic        paint_en;
   logic        pix_valid;
   logic        pix_ready;
   logic [16:0] pix_addr;
   logic [15:0] pix_data;
   logic        busy;
   logic [15:0] stamp_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model of the stamp trigger rule
   bit m_armed   = 0;
   int m_lx      = 0;
   int m_ly      = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   cursor_brush_painter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .brush_color  (brush_color),
      .brush_radius (brush_radius),
      .paint_en     (paint_en),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_addr     (pix_addr),
      .pix_data     (pix_data),
      .busy         (busy),
      .stamp_count  (stamp_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic drop_paint(input int n);
      paint_en = 1'b0;
      repeat (n) @(negedge clk);
      m_armed = 0;
   endtask

   // Apply one cursor/brush setting with paint_en high and observe the result.
   // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready.
   task automatic do_stamp(input int cx, input int cy, input int r, input int col,
                           input int rmode, input bit drop_mid);
      bit          trig;
      bit          seen = 0;
      bit          done = 0;
      bit          prev_stall = 0;
      int          busy_cnt = 0;
      int          stalls = 0;
      int          n;
      logic [16:0] prev_a = '0;
      logic [15:0] prev_d = '0;
      int          exp_a[$];
      int          exp_d[$];
      int          got_a[$];
      int          got_d[$];

      trig = !m_armed || (cx != m_lx) || (cy != m_ly);
      if (trig) begin
         for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
               int x;
               int y;
               x = cx + dx;
               y = cy + dy;
               if (x >= 0 && x < 320 && y >= 0 && y < 240) begin
                  exp_a.push_back(y * 320 + x);
                  exp_d.push_back(col);
               end
            end
         end
      end

      cursor_x     = 16'(cx);
      cursor_y     = 16'(cy);
      brush_radius = 3'(r);
      brush_color  = 16'(col);
      paint_en     = 1'b1;

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         case (rmode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ((k % 3) == 2);
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         if (prev_stall) begin
            check_val("hold_valid", 32'(pix_valid), 32'd1);
            check_val("hold_addr", 32'(pix_addr), 32'(prev_a));
            check_val("hold_data", 32'(pix_data), 32'(prev_d));
         end
         prev_stall = pix_valid && !pix_ready;
         prev_a     = pix_addr;
         prev_d     = pix_data;
         if (prev_stall) stalls++;
         if (pix_valid && pix_ready) begin
            got_a.push_back(int'(pix_addr));
            got_d.push_back(int'(pix_data));
         end
         if (busy) begin
            busy_cnt++;
            seen = 1;
            if (busy_cnt == 2) begin
               // stamp inputs already latched; these must not leak into this stamp
               cursor_x     = 16'($urandom);
               cursor_y     = 16'($urandom);
               brush_color  = 16'($urandom);
               brush_radius = 3'($urandom);
               if (drop_mid) paint_en = 1'b0;
            end
         end else if (seen) begin
            done = 1;
            break;
         end
         if (!trig && k == 20) begin
            done = 1;
            break;
         end
      end

      check_val("stamp_finished", 32'(done), 32'd1);
      if (trig) check_val("busy_cycles", busy_cnt, (2 * r + 1) * (2 * r + 1) + 3 + stalls);
      else      check_val("no_stamp_busy", busy_cnt, 0);
      check_val("write_count", got_a.size(), exp_a.size());
      n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         check_val("write_addr", got_a[i], exp_a[i]);
         check_val("write_data", got_d[i], exp_d[i]);
      end

      if (trig) begin
         exp_count = (exp_count + 1) & 16'hFFFF;
         m_armed   = 1;
         m_lx      = cx;
         m_ly      = cy;
      end
      check_val("stamp_count", 32'(stamp_count), exp_count);

      if (!paint_en) begin
         @(negedge clk);
         m_armed = 0;
      end
   endtask

   initial begin
      int nw;
      reset_n      = 1'b0;
      paint_en     = 1'b0;
      pix_ready    = 1'b1;
      cursor_x     = '0;
      cursor_y     = '0;
      brush_color  = '0;
      brush_radius = '0;
      repeat (3) @(negedge clk);
      check_val("rst_pix_valid", 32'(pix_valid), 32'd0);
      check_val("rst_pix_addr", 32'(pix_addr), 32'd0);
      check_val("rst_pix_data", 32'(pix_data), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_stamp_count", 32'(stamp_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // single pixel, then 3x3, screen corner, and backpressure
      do_stamp(10, 20, 0, 16'hF800, 0, 0);
      do_stamp(100, 50, 1, 16'h07E0, 0, 0);
      do_stamp(0, 0, 2, 16'h001F, 0, 0);
      do_stamp(100, 50, 1, 16'hABCD, 1, 0);

      // stationary cursor: one stamp only; move and re-arm give more
      do_stamp(10, 20, 0, 16'h1234, 0, 0);
      repeat (5) do_stamp(10, 20, 0, 16'h1234, 0, 0);
      do_stamp(11, 20, 0, 16'h1234, 0, 0);
      drop_paint(2);
      do_stamp(11, 20, 0, 16'h1234, 0, 0);

      // reset in the middle of a stamp
      drop_paint(2);
      cursor_x     = 16'd100;
      cursor_y     = 16'd50;
      brush_radius = 3'd1;
      brush_color  = 16'h5555;
      paint_en     = 1'b1;
      nw = 0;
      for (int k = 0; k < 60 && nw < 4; k++) begin
         @(negedge clk);
         pix_ready = 1'b1;
         if (pix_valid && pix_ready) nw++;
      end
      @(negedge clk);
      reset_n  = 1'b0;
      paint_en = 1'b0;
      @(negedge clk);
      check_val("midrst_writes", nw, 4);
      check_val("midrst_pix_valid", 32'(pix_valid), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_stamp_count", 32'(stamp_count), 32'd0);
      reset_n   = 1'b1;
      exp_count = 0;
      m_armed   = 0;
      @(negedge clk);
      do_stamp(400, 10, 0, 16'h7777, 0, 0);

      // randomized stamps
      for (int it = 0; it < 40; it++) begin
         int cx;
         int cy;
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            cx = m_lx;
            cy = m_ly;
         end else if (sel < 7) begin
            cx = int'($urandom_range(0, 330));
            cy = int'($urandom_range(0, 250));
         end else if (sel < 9) begin
            cx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(311, 327));
            cy = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(231, 247));
         end else begin
            cx = int'($urandom_range(65520, 65535));
            cy = int'($urandom_range(0, 65535));
         end
         if ($urandom_range(0, 5) == 0) drop_paint(1);
         do_stamp(cx, cy, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
      end

      paint_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
